memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Single-port RAM arbiter directly downstream of coherence_control (data side) and the icache.
//  Grants one requester at a time and steers its request to the RAM port.
//  Returns load data and wait release to the granted side only.
//  Data side has strict priority; optional starvation guard for instruction side.
// PARAMETERS
//  BAD           32'hBAD1BAD1  load value returned on a RAM ERROR completion
//  STARVE_LIMIT  8             consecutive data grants before a pending iREN is forced (STARVE_EN only)
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RST       in   1   synchronous, active-high reset
//  dREN      in   1   data read request (from coherence_control)
//  dWEN      in   1   data write request (from coherence_control write-back FIFO)
//  daddr     in   32  data address
//  dstore    in   32  data write value
//  dload     out  32  data read value, valid when dwait=0
//  dwait     out  1   1 = data request not complete
//  iREN      in   1   instruction read request (from icache)
//  iaddr     in   32  instruction address
//  iload     out  32  instruction read value, valid when iwait=0
//  iwait     out  1   1 = instruction request not complete
//  ramREN    out  1   RAM read strobe
//  ramWEN    out  1   RAM write strobe
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write value
//  ramload   in   32  RAM read value
//  ramstate  in   2   0=FREE 1=BUSY 2=ACCESS 3=ERROR
//  err       out  1   sticky: a RAM ERROR was seen since reset
// BEHAVIOUR
//  Reset (RST=1 at edge): state=IDLE, err=0, starve count=0.
//  Reset output values: dwait=iwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, dload=iload=0.
//  RST mid-transaction abandons it at once; no completion pulse is given.
//  FSM states IDLE, DGRANT, IGRANT; state register only, RAM outputs combinational from state.
//  IDLE:   no RAM strobes.
//          (dREN|dWEN) -> DGRANT; else iREN -> IGRANT; else stay.
//          Simultaneous d and i requests: DGRANT (unless starvation guard fires).
//  DGRANT: ramaddr=daddr.
//          If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. dWEN overrides dREN if both are high.
//          Else: ramREN=dREN.
//  IGRANT: ramREN=1, ramaddr=iaddr, ramstore=0.
//  Completion:
//   - Granted state and ramstate==ACCESS -> granted wait=0 for exactly that cycle.
//   - On a read, granted load=ramload. Next state=IDLE.
//  Error:
//   - Granted state and ramstate==ERROR -> completes like ACCESS, but load=BAD.
//   - err set; err clears only on RST.
//  Request withdrawn while granted (d: dREN=dWEN=0; i: iREN=0):
//   - Strobes drop that cycle, no completion, next state=IDLE.
//  Non-granted side: wait=1, load=0 at all times.
//  Latency:
//   - Request seen in IDLE at cycle N -> strobes at N+1.
//   - Earliest wait=0 at N+1 if RAM returns ACCESS the same cycle.
//   - Back-to-back: IDLE is always visited for one cycle between grants.
//  FREE/BUSY in a grant state: hold strobes and address, wait=1.
// CONFIGURATION
//  MEM_ARB_STARVE_EN defined:
//   - 4-bit counter counts completed DGRANTs while iREN=1.
//   - Counter clears on any IGRANT completion or when iREN=0.
//   - If counter>=STARVE_LIMIT, IDLE goes to IGRANT even with a data request pending.
//   - Counter saturates, never wraps.
//  MEM_ARB_STARVE_EN undefined: strict data priority; no counter is built.
// TESTING
//  1 Reset: RST=1 two cycles, all requests high -> dwait=iwait=1, ramREN=ramWEN=0, err=0.
//  2 iREN=1, iaddr=0x100, RAM ACCESS after 3 BUSY, ramload=0x1234
//    -> iwait=0 one cycle, iload=0x1234, ramaddr=0x100.
//  3 dREN=iREN=1 together -> DGRANT first.
//    dwait releases, IDLE one cycle, then IGRANT; iwait releases.
//  4 dWEN=dREN=1, daddr=0x40, dstore=0xCAFE -> ramWEN=1, ramREN=0, ramstore=0xCAFE.
//  5 DGRANT, ramstate=ERROR -> dwait=0, dload=0xBAD1BAD1, err=1 held afterwards.
//  6 STARVE_EN, STARVE_LIMIT=8: continuous dREN plus iREN
//    -> after 8 data completions the next grant is IGRANT; undefined -> iwait stays 1.

Source files
------------

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data side (coherence_control) has strict priority over the icache.
// Latency: request seen in IDLE at cycle N drives RAM strobes at N+1; wait drops in the ACCESS/ERROR cycle.
// Backpressure: RAM FREE/BUSY holds the grant; define MEM_ARB_STARVE_EN to build the icache starvation guard.
module memory_arbiter #(
   parameter logic [31:0] BAD          = 32'hBAD1BAD1,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

   localparam logic [1:0] RAM_ERROR = 2'd3;

   state_t state;
   logic   d_req;
   logic   ram_done;
   logic   d_done;
   logic   i_done;
   logic   starve;

   assign d_req    = dREN | dWEN;
   // ACCESS (2) and ERROR (3) both end the RAM access.
   assign ram_done = ramstate[1];
   assign d_done   = !RST && (state == DGRANT) && d_req && ram_done;
   assign i_done   = !RST && (state == IGRANT) && iREN && ram_done;

`ifdef MEM_ARB_STARVE_EN
   logic [3:0] starve_cnt;

   assign starve = iREN && ({28'd0, starve_cnt} >= STARVE_LIMIT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         starve_cnt <= 4'd0;
      end else if (!iREN || i_done) begin
         starve_cnt <= 4'd0;
      end else if (d_done && starve_cnt != 4'hF) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   assign starve = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (starve)     state <= IGRANT;
               else if (d_req) state <= DGRANT;
               else if (iREN)  state <= IGRANT;
            end
            DGRANT: if (!d_req || ram_done) state <= IDLE;
            IGRANT: if (!iREN || ram_done)  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         err <= 1'b0;
      end else if ((d_done || i_done) && ramstate == RAM_ERROR) begin
         err <= 1'b1;
      end
   end

   // Reset overrides the state so an abandoned grant never emits a completion.
   always_comb begin
      dwait    = 1'b1;
      iwait    = 1'b1;
      dload    = 32'd0;
      iload    = 32'd0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      if (!RST) begin
         case (state)
            DGRANT: begin
               ramaddr = daddr;
               if (dWEN) begin
                  ramWEN   = 1'b1;
                  ramstore = dstore;
               end else begin
                  ramREN = dREN;
               end
               if (d_done) begin
                  dwait = 1'b0;
                  if (ramstate == RAM_ERROR) dload = BAD;
                  else if (!dWEN)            dload = ramload;
               end
            end
            IGRANT: begin
               ramaddr = iaddr;
               ramREN  = iREN;
               if (i_done) begin
                  iwait = 1'b0;
                  iload = (ramstate == RAM_ERROR) ? BAD : ramload;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_memory_arbiter;

   localparam logic [31:0] BAD   = 32'hBAD1BAD1;
   localparam int          LIMIT = 8;
`ifdef MEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        dREN, dWEN, iREN;
   logic [31:0] daddr, dstore, iaddr, ramload;
   logic [1:0]  ramstate;
   logic [31:0] dload, iload, ramaddr, ramstore;
   logic        dwait, iwait, ramREN, ramWEN, err;

   int n_checks = 0;
   int n_pass   = 0;
   bit check_en = 1'b0;

   memory_arbiter #(.BAD(BAD), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RST(RST),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
   endtask

   // Model: who owns the RAM (0 nobody, 1 data, 2 instruction), how many data
   // grants finished while the icache kept asking, and the sticky error flag.
   int owner   = 0;
   int dstreak = 0;
   bit err_m   = 1'b0;

   always @(negedge CLK) begin
      bit          e_dwait, e_iwait, e_rren, e_rwen, done, still;
      logic [31:0] e_dload, e_iload, e_addr, e_store;
      if (check_en) begin
         e_dwait = 1'b1; e_iwait = 1'b1; e_rren = 1'b0; e_rwen = 1'b0;
         e_dload = '0;   e_iload = '0;   e_addr = '0;   e_store = '0;
         done    = 1'b0;
         still   = (owner == 1) ? (dREN || dWEN) : iREN;
         if (!RST && owner == 1) begin
            e_addr = daddr;
            e_rwen = dWEN;
            e_rren = dREN && !dWEN;
            if (dWEN) e_store = dstore;
            done = still && (ramstate == 2'd2 || ramstate == 2'd3);
            if (done) begin
               e_dwait = 1'b0;
               e_dload = (ramstate == 2'd3) ? BAD : (dWEN ? 32'h0 : ramload);
            end
         end else if (!RST && owner == 2) begin
            e_addr = iaddr;
            e_rren = iREN;
            done   = still && (ramstate == 2'd2 || ramstate == 2'd3);
            if (done) begin
               e_iwait = 1'b0;
               e_iload = (ramstate == 2'd3) ? BAD : ramload;
            end
         end
         chk("m_dwait", dwait, e_dwait);
         chk("m_iwait", iwait, e_iwait);
         chk("m_dload", dload, e_dload);
         chk("m_iload", iload, e_iload);
         chk("m_ramREN", ramREN, e_rren);
         chk("m_ramWEN", ramWEN, e_rwen);
         chk("m_ramaddr", ramaddr, e_addr);
         chk("m_ramstore", ramstore, e_store);
         chk("m_err", err, err_m);
         if (RST) begin
            owner = 0; dstreak = 0; err_m = 1'b0;
         end else begin
            if (done && ramstate == 2'd3) err_m = 1'b1;
            if (!iREN || (done && owner == 2))              dstreak = 0;
            else if (done && owner == 1 && dstreak < 15)    dstreak++;
            if (owner == 0) begin
               if (STARVE && iREN && dstreak >= LIMIT) owner = 2;
               else if (dREN || dWEN)                  owner = 1;
               else if (iREN)                          owner = 2;
            end else if (done || !still) begin
               owner = 0;
            end
         end
      end
   end

   initial begin
      int nd, first_i, r;
      RST = 1'b1; dREN = 1'b1; dWEN = 1'b1; iREN = 1'b1;
      daddr = '0; dstore = '0; iaddr = '0; ramload = '0; ramstate = 2'd2;

      // Reset held two cycles with every request high.
      @(posedge CLK); #1; check_en = 1'b1;
      @(negedge CLK);
      chk("rst_dwait", dwait, 1); chk("rst_iwait", iwait, 1);
      chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0); chk("rst_err", err, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rst2_ramaddr", ramaddr, 0); chk("rst2_dwait", dwait, 1);
      @(posedge CLK); #1; RST = 1'b0; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0; ramstate = 2'd0;
      @(negedge CLK);

      // Instruction read: three BUSY cycles, then ACCESS.
      @(posedge CLK); #1; iREN = 1'b1; iaddr = 32'h100; ramstate = 2'd1;
      @(negedge CLK); chk("t2_idle_ramREN", ramREN, 0);
      repeat (3) begin
         @(posedge CLK); #1;
         @(negedge CLK); chk("t2_busy_iwait", iwait, 1); chk("t2_busy_ramREN", ramREN, 1);
      end
      @(posedge CLK); #1; ramstate = 2'd2; ramload = 32'h1234;
      @(negedge CLK);
      chk("t2_iwait", iwait, 0); chk("t2_iload", iload, 32'h1234); chk("t2_ramaddr", ramaddr, 32'h100);
      @(posedge CLK); #1; iREN = 1'b0; ramstate = 2'd0;
      @(negedge CLK); chk("t2_after_iwait", iwait, 1);

      // Simultaneous requests: data first, one IDLE gap, then instruction.
      @(posedge CLK); #1; dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h300;
      ramstate = 2'd2; ramload = 32'h55;
      @(negedge CLK); chk("t3_idle_dwait", dwait, 1);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("t3_dwait", dwait, 0); chk("t3_iwait", iwait, 1); chk("t3_dload", dload, 32'h55);
      chk("t3_daddr", ramaddr, 32'h200);
      @(posedge CLK); #1; dREN = 1'b0;
      @(negedge CLK); chk("t3_gap_ramREN", ramREN, 0); chk("t3_gap_iwait", iwait, 1);
      @(posedge CLK); #1;
      @(negedge CLK); chk("t3_iwait", iwait, 0); chk("t3_iaddr", ramaddr, 32'h300);
      @(posedge CLK); #1; iREN = 1'b0; ramstate = 2'd0;
      @(negedge CLK);

      // Write wins over read.
      @(posedge CLK); #1; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'hCAFE; ramstate = 2'd1;
      @(negedge CLK);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("t4_ramWEN", ramWEN, 1); chk("t4_ramREN", ramREN, 0);
      chk("t4_ramstore", ramstore, 32'hCAFE); chk("t4_ramaddr", ramaddr, 32'h40);
      @(posedge CLK); #1; ramstate = 2'd2;
      @(negedge CLK); chk("t4_dwait", dwait, 0);
      @(posedge CLK); #1; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
      @(negedge CLK);

      // RAM error on a data read.
      @(posedge CLK); #1; dREN = 1'b1; daddr = 32'h80; ramstate = 2'd3;
      @(negedge CLK); chk("t5_err_before", err, 0);
      @(posedge CLK); #1;
      @(negedge CLK); chk("t5_dwait", dwait, 0); chk("t5_dload", dload, 32'hBAD1BAD1);
      @(posedge CLK); #1; dREN = 1'b0; ramstate = 2'd0;
      @(negedge CLK); chk("t5_err_set", err, 1);
      repeat (3) begin @(posedge CLK); #1; end
      @(negedge CLK); chk("t5_err_held", err, 1);

      // Continuous data traffic with the icache waiting.
      @(posedge CLK); #1; dREN = 1'b1; iREN = 1'b1; ramstate = 2'd2;
      nd = 0; first_i = -1;
      for (int c = 0; c < 24; c++) begin
         @(negedge CLK);
         if (!iwait && first_i < 0) first_i = nd;
         if (!dwait) nd++;
         @(posedge CLK); #1;
      end
      dREN = 1'b0; iREN = 1'b0; ramstate = 2'd0;
      if (STARVE) chk("t6_dgrants_before_igrant", first_i, 8);
      else begin
         chk("t6_iwait_never_released", first_i, -1);
         chk("t6_data_completions", nd, 12);
      end
      @(negedge CLK);

      // Randomized traffic; requests tend to persist across cycles.
      for (int c = 0; c < 3000; c++) begin
         @(posedge CLK); #1;
         RST = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) dREN = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) dWEN = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) iREN = ($urandom_range(0, 1) == 1);
         daddr = $urandom; dstore = $urandom; iaddr = $urandom; ramload = $urandom;
         r = $urandom_range(0, 9);
         ramstate = (r == 0) ? 2'd0 : (r <= 3) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
      end
      @(negedge CLK);
      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
